// File: rtl/fsm_vector_sequencer_pkg.sv
// Shared types for the vector sequencer: FSM state encoding and the packed
// table entry {i, j, exp_x, exp_y}.
package fsm_seq_pkg;

  typedef enum logic [2:0] {IDLE, PREP, RUN, DRAIN, DONE} seq_state_t;

  typedef struct packed {
    logic i;
    logic j;
    logic exp_x;
    logic exp_y;
  } seq_vec_t;

  localparam int MAX_RESP_LAT = 4;

endpackage

// File: rtl/fsm_vector_sequencer_if.sv
// Host-side bundle of the vector sequencer: table write port, run control
// and run results.
interface fsm_vector_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [3:0]       wr_data;
  logic [AW:0]      len;
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [AW-1:0]    first_err;

  modport master (
    output wr_en, wr_addr, wr_data, len, start,
    input  busy, done, pass, err_cnt, first_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start,
    output busy, done, pass, err_cnt, first_err
  );

endinterface

// File: rtl/fsm_vector_sequencer_mem.sv
// Vector table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fsm_seq_mem
  import fsm_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  seq_vec_t      wdata,
  input  logic [AW-1:0] raddr,
  output seq_vec_t      rdata
);

  seq_vec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_vector_sequencer.sv
// Drives stored {i,j} vectors into a small control FSM and checks its {x,y}
// response after RESP_LAT clocks, reporting error count and first failure.
//
// state | meaning
// IDLE  | waiting for start; table writable
// PREP  | one cycle with the FSM held in reset
// RUN   | one table vector applied per cycle
// DRAIN | RESP_LAT cycles for the last responses to be checked
// DONE  | done pulse, pass valid
module fsm_vector_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int RESP_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  fsm_vector_sequencer_if.slave  host,
  output logic                   dut_rstn,
  output logic                   i,
  output logic                   j,
  input  logic                   x,
  input  logic                   y
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(MAX_RESP_LAT);

  seq_state_t                  state;
  logic [LW-1:0]               len_q;
  logic [LW-1:0]               idx;
  logic [DW-1:0]               drain_cnt;
  logic                        busy_q;
  logic                        done_q;
  logic                        pass_q;
  logic [CNT_W-1:0]            err_q;
  logic [AW-1:0]               first_q;
  logic [RESP_LAT-1:0]         dl_vld;
  logic [RESP_LAT-1:0]         dl_x;
  logic [RESP_LAT-1:0]         dl_y;
  logic [RESP_LAT-1:0][AW-1:0] dl_idx;
  logic [AW-1:0]               rd_addr;
  seq_vec_t                    rd_vec;
  logic                        drive;

  fsm_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (host.wr_en && !busy_q),
    .waddr (host.wr_addr),
    .wdata (seq_vec_t'(host.wr_data)),
    .raddr (rd_addr),
    .rdata (rd_vec)
  );

  assign rd_addr = idx[AW-1:0];
  // A vector is launched on the PREP->RUN edge and on every RUN edge until len is reached.
  assign drive   = ((state == PREP) && (len_q != '0)) ||
                   ((state == RUN)  && (idx != len_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
      dut_rstn  <= 1'b0;
      i         <= 1'b0;
      j         <= 1'b0;
      len_q     <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      dl_vld    <= '0;
      dl_x      <= '0;
      dl_y      <= '0;
      dl_idx    <= '0;
    end else begin
      for (int n = RESP_LAT - 1; n > 0; n--) begin
        dl_vld[n] <= dl_vld[n-1];
        dl_x[n]   <= dl_x[n-1];
        dl_y[n]   <= dl_y[n-1];
        dl_idx[n] <= dl_idx[n-1];
      end
      dl_vld[0] <= drive;
      dl_x[0]   <= rd_vec.exp_x;
      dl_y[0]   <= rd_vec.exp_y;
      dl_idx[0] <= rd_addr;
      i         <= drive ? rd_vec.i : 1'b0;
      j         <= drive ? rd_vec.j : 1'b0;
      if (drive) idx <= idx + LW'(1);

      if (dl_vld[RESP_LAT-1] && ({x, y} != {dl_x[RESP_LAT-1], dl_y[RESP_LAT-1]})) begin
        if (err_q != '1) err_q <= err_q + CNT_W'(1);
        if (err_q == '0) first_q <= dl_idx[RESP_LAT-1];
      end

      case (state)
        IDLE: begin
          if (host.start) begin
            len_q    <= (host.len > LW'(DEPTH)) ? LW'(DEPTH) : host.len;
            err_q    <= '0;
            first_q  <= '0;
            pass_q   <= 1'b0;
            idx      <= '0;
            busy_q   <= 1'b1;
            dut_rstn <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          dut_rstn <= 1'b1;
          if (len_q == '0) begin
            drain_cnt <= DW'(RESP_LAT - 1);
            state     <= DRAIN;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (idx == len_q) begin
            drain_cnt <= DW'(RESP_LAT - 1);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            done_q <= 1'b1;
            pass_q <= (err_q == '0);
            state  <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.pass      = pass_q;
  assign host.err_cnt   = err_q;
  assign host.first_err = first_q;

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Scoreboarded bench for fsm_vector_sequencer driving a small parity-style
// control FSM; expected run results come from a table-walking reference model.
module tb_fsm_vector_sequencer;

  localparam int DEPTH    = 16;
  localparam int RESP_LAT = 1;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dut_rstn, i, j, x, y;
  logic s;

  fsm_vector_sequencer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) hif ();

  fsm_vector_sequencer #(.DEPTH(DEPTH), .RESP_LAT(RESP_LAT), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .host     (hif),
    .dut_rstn (dut_rstn),
    .i        (i),
    .j        (j),
    .x        (x),
    .y        (y)
  );

  always #5 clk = ~clk;

  // FSM under test: one state bit toggled by i, Mealy outputs.
  always_ff @(posedge clk or negedge dut_rstn) begin
    if (!dut_rstn) s <= 1'b0;
    else           s <= s ^ i;
  end
  assign x = s ^ j;
  assign y = i & ~s;

  typedef struct {
    int pass;
    int err;
    int first;
    int lat;
    int t0;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] tbl[DEPTH];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         len0_watch = 1'b0;
  int         len0_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outcome of a run: walk the table, tracking the FSM state as parity of past i.
  function automatic exp_t model(int l, int t0);
    exp_t e;
    int   le;
    bit   st;
    bit   xr, yr;
    logic [3:0] v;
    le      = (l > DEPTH) ? DEPTH : l;
    e.err   = 0;
    e.first = 0;
    st      = 1'b0;
    for (int k = 0; k < le; k++) begin
      v  = tbl[k];
      xr = st ^ v[2];
      yr = v[3] & ~st;
      if (v[1] != xr || v[0] != yr) begin
        if (e.err == 0) e.first = k;
        e.err++;
      end
      st = st ^ v[3];
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = 2 + le + RESP_LAT;
    e.t0   = t0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rstn && hif.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("pass", int'(hif.pass), mon_e.pass);
        chk("err_cnt", int'(hif.err_cnt), mon_e.err);
        chk("first_err", int'(hif.first_err), mon_e.first);
        chk("latency", cyc - mon_e.t0, mon_e.lat);
        chk("busy_with_done", int'(hif.busy), 1);
      end
    end
    if (len0_watch && hif.busy && (i || j)) len0_bad <= len0_bad + 1;
  end

  task automatic write_vec(int a, logic [3:0] d);
    @(negedge clk);
    hif.wr_en   = 1'b1;
    hif.wr_addr = 4'(a);
    hif.wr_data = d;
    @(negedge clk);
    hif.wr_en   = 1'b0;
    tbl[a]      = d;
  endtask

  // mode 0: exp matches the FSM, 1: both exp bits wrong, 2: random exp
  task automatic build_table(int mode);
    bit st, iv, jv, xg, yg;
    st = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      iv = 1'($urandom_range(1));
      jv = 1'($urandom_range(1));
      xg = st ^ jv;
      yg = iv & ~st;
      case (mode)
        0:       write_vec(k, {iv, jv, xg, yg});
        1:       write_vec(k, {iv, jv, ~xg, ~yg});
        default: write_vec(k, {iv, jv, 2'($urandom_range(3))});
      endcase
      st = st ^ iv;
    end
  endtask

  task automatic start_run(int l, bit expect_done);
    @(negedge clk);
    hif.len   = 5'(l);
    hif.start = 1'b1;
    if (expect_done) sb.push_back(model(l, cyc));
    @(negedge clk);
    hif.start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    hif.wr_en   = 1'b0;
    hif.wr_addr = '0;
    hif.wr_data = '0;
    hif.len     = '0;
    hif.start   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(hif.busy), 0);
    chk("rst_done", int'(hif.done), 0);
    chk("rst_pass", int'(hif.pass), 0);
    chk("rst_err_cnt", int'(hif.err_cnt), 0);
    chk("rst_first_err", int'(hif.first_err), 0);
    chk("rst_i", int'(i), 0);
    chk("rst_j", int'(j), 0);
    chk("rst_dut_rstn", int'(dut_rstn), 0);
    rstn = 1'b1;

    // golden 4-vector run, pass stays up after done
    build_table(0);
    start_run(4, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("pass_held", int'(hif.pass), 1);

    // single wrong expectation at vector 2
    write_vec(2, tbl[2] ^ 4'b0010);
    start_run(4, 1'b1);
    wait_idle();
    write_vec(2, tbl[2] ^ 4'b0010);

    // empty run
    len0_watch = 1'b1;
    start_run(0, 1'b1);
    wait_idle();
    len0_watch = 1'b0;
    chk("len0_ij_zero", len0_bad, 0);

    // start and write while running are ignored
    start_run(4, 1'b1);
    @(negedge clk);
    chk("run_busy", int'(hif.busy), 1);
    hif.start   = 1'b1;
    hif.len     = 5'd2;
    hif.wr_en   = 1'b1;
    hif.wr_addr = '0;
    hif.wr_data = tbl[0] ^ 4'b0011;
    @(negedge clk);
    hif.start   = 1'b0;
    hif.wr_en   = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    start_run(4, 1'b1);
    wait_idle();

    // write and start in the same idle cycle: run sees the new entry
    @(negedge clk);
    d           = tbl[0] ^ 4'b0001;
    hif.wr_en   = 1'b1;
    hif.wr_addr = '0;
    hif.wr_data = d;
    hif.len     = 5'd1;
    hif.start   = 1'b1;
    tbl[0]      = d;
    sb.push_back(model(1, cyc));
    @(negedge clk);
    hif.wr_en   = 1'b0;
    hif.start   = 1'b0;
    wait_idle();
    write_vec(0, d ^ 4'b0001);

    // abort during RUN cycle 2
    start_run(4, 1'b0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_busy", int'(hif.busy), 0);
    chk("abort_i", int'(i), 0);
    chk("abort_j", int'(j), 0);
    chk("abort_dut_rstn", int'(dut_rstn), 0);
    chk("abort_done", int'(hif.done), 0);
    chk("abort_err_cnt", int'(hif.err_cnt), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_dut_rstn_held", int'(dut_rstn), 0);
    chk("abort_idle", int'(hif.busy), 0);

    // oversize length, every expectation wrong
    build_table(1);
    start_run(31, 1'b1);
    wait_idle();

    for (int it = 0; it < 6; it++) begin
      build_table(int'($urandom_range(2)));
      start_run(int'($urandom_range(31)), 1'b1);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
